// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-unit state encodings and constants
package cpu_pkg;
   typedef enum logic [1:0] {S_RST = 2'd0, S_FETCH = 2'd1, S_HOLD = 2'd2} state_e;
   localparam int WORD_BYTES = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: sequential, branch and jump next-PC candidates
module pc_target_calc
   import cpu_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [25:0] instr_i,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] branch_addr_o,
   output logic [31:0] jump_addr_o
);
   assign pc_plus4_o    = pc_i + 32'(WORD_BYTES);
   assign branch_addr_o = pc_plus4_o + {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
   assign jump_addr_o   = {pc_plus4_o[31:28], instr_i, 2'b00};
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter owner and fetch/hold/retire handshake
module pc_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   input  logic [31:0] next_pc_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] branch_addr_o,
   output logic [31:0] jump_addr_o,
   output logic        misalign_err_o
);
   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d, instr_q, instr_d;
   logic        err_q, err_d, fetch_done, retire;
   always_comb begin
      fetch_done = state_q == S_FETCH && imem_ack_i;
      retire     = state_q == S_HOLD && instr_ready_i;
      state_d    = state_q == S_RST ? S_FETCH :
                   fetch_done ? S_HOLD :
                   retire ? S_FETCH : state_q;
      pc_d       = retire ? {next_pc_i[31:2], 2'b00} : pc_q;
      instr_d    = fetch_done ? imem_rdata_i : instr_q;
      err_d      = err_q | (retire && next_pc_i[1:0] != 2'b00);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RST;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         err_q   <= err_d;
      end
   end
   assign imem_req_o     = state_q == S_FETCH;
   assign imem_addr_o    = pc_q;
   assign instr_valid_o  = state_q == S_HOLD;
   assign instr_o        = instr_q;
   assign pc_o           = pc_q;
   assign misalign_err_o = err_q;
   pc_target_calc u_targets (
      .pc_i          (pc_q),
      .instr_i       (instr_q[25:0]),
      .pc_plus4_o    (pc_plus4_o),
      .branch_addr_o (branch_addr_o),
      .jump_addr_o   (jump_addr_o)
   );
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and random checks against a transaction-level model
module tb_pc_fetch_unit;
   logic        clk = 1'b0, rst = 1'b1;
   logic        imem_req, imem_ack = 1'b0, instr_valid, instr_ready = 1'b0, misalign_err;
   logic [31:0] imem_addr, imem_rdata = '0, instr, next_pc = '0, pc, pc_plus4, branch_addr, jump_addr;
   int          n_checks = 0, n_fail = 0;
   // Model: "starting" = one idle cycle after reset, "holding" = an instruction is owned by decode.
   bit          m_starting, m_holding, m_err;
   logic [31:0] m_pc, m_instr;

   always #5 clk = ~clk;

   pc_fetch_unit #(.RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst),
      .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
      .instr_o(instr), .instr_valid_o(instr_valid), .instr_ready_i(instr_ready), .next_pc_i(next_pc),
      .pc_o(pc), .pc_plus4_o(pc_plus4), .branch_addr_o(branch_addr), .jump_addr_o(jump_addr),
      .misalign_err_o(misalign_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_starting = 1; m_holding = 0; m_pc = 32'h0; m_instr = 32'h0; m_err = 0;
      end else if (m_starting) m_starting = 0;
      else if (!m_holding) begin
         if (imem_ack) begin m_instr = imem_rdata; m_holding = 1; end
      end else if (instr_ready) begin
         m_pc = next_pc & ~32'h3;
         m_err = m_err | (next_pc % 4 != 0);
         m_holding = 0;
      end
   endtask

   task automatic tick();
      logic [31:0] p4, br, jp;
      model_edge();
      @(posedge clk);
      #1;
      p4 = m_pc + 4;
      br = p4 + 32'(int'($signed(m_instr[15:0])) * 4);
      jp = (p4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
      chk("imem_req", {31'b0, imem_req}, {31'b0, !m_starting && !m_holding});
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_holding});
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("instr", instr, m_instr);
      chk("pc_plus4", pc_plus4, p4);
      chk("branch_addr", branch_addr, br);
      chk("jump_addr", jump_addr, jp);
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
   endtask

   task automatic fetch(input logic [31:0] data);
      imem_ack = 1; imem_rdata = data; instr_ready = 0; tick();
      imem_ack = 0;
   endtask

   task automatic retire(input logic [31:0] npc);
      instr_ready = 1; next_pc = npc; tick();
      instr_ready = 0;
   endtask

   initial begin
      repeat (3) tick();
      chk("t1 req after rst", {31'b0, imem_req}, 32'h0);
      rst = 0;
      tick();
      chk("t1 first req", {31'b0, imem_req}, 32'h1);
      chk("t1 first addr", imem_addr, 32'h0);
      fetch(32'h1234_5678);
      chk("t2 instr", instr, 32'h1234_5678);
      chk("t2 pc_plus4", pc_plus4, 32'h4);
      retire(32'h100);
      fetch(32'h0000_FFFF);
      chk("t3 branch back", branch_addr, 32'h100);
      retire(32'h100);
      fetch(32'h0000_0003);
      chk("t3 branch fwd", branch_addr, 32'h110);
      retire(32'hF000_0000);
      fetch(32'h0000_0040);
      chk("t4 jump", jump_addr, 32'hF000_0100);
      retire(32'hF000_0100);
      chk("t4 addr", imem_addr, 32'hF000_0100);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t5 req stable", {31'b0, imem_req}, 32'h1);
         chk("t5 addr stable", imem_addr, 32'hF000_0100);
      end
      fetch(32'hDEAD_BEEF);
      retire(32'h40);
      tick();
      tick();
      rst = 1; imem_ack = 1; imem_rdata = 32'hCAFE_F00D;
      tick();
      chk("t5 rst pc", pc, 32'h0);
      chk("t5 no capture", instr, 32'h0);
      rst = 0;
      tick();
      chk("t5 ack in rst ignored", {31'b0, instr_valid}, 32'h0);
      imem_ack = 0;
      fetch(32'h0);
      retire(32'h0000_0203);
      chk("t6 misalign", {31'b0, misalign_err}, 32'h1);
      chk("t6 aligned addr", imem_addr, 32'h200);
      fetch(32'h0);
      retire(32'hFFFF_FFFC);
      fetch(32'h0);
      chk("t6 wrap", pc_plus4, 32'h0);
      chk("t6 sticky", {31'b0, misalign_err}, 32'h1);
      for (int i = 0; i < 400; i++) begin
         rst         = $urandom_range(0, 39) == 0;
         imem_ack    = $urandom_range(0, 1) == 1;
         instr_ready = $urandom_range(0, 2) != 0;
         imem_rdata  = $urandom;
         next_pc     = $urandom_range(0, 3) == 0 ? $urandom : $urandom & ~32'h3;
         tick();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
